pic_io_port: RTL and testbench



---
 rtl/pic_io_pkg.sv | 12 +
 rtl/pic_sync_chain.sv | 37 +++
 rtl/pic_io_port.sv | 102 ++++++++++
 tb/tb_pic_io_port.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pic_io_pkg.sv
// Shared constants for the PIC16C55 GPIO port stage: width limit, the
// all-input direction value and the BSF/BCF bit-op encoding.
package pic_io_pkg;

  localparam int PIC_PORT_MAX_W = 8;

  localparam logic [PIC_PORT_MAX_W-1:0] TRIS_ALL_INPUT = '1;

  localparam logic BIT_SET = 1'b1;
  localparam logic BIT_CLR = 1'b0;

endpackage

// File: rtl/pic_sync_chain.sv
// Multi-flop input synchroniser for the port pins; every stage resets to 0.
// X/Z on a pin passes through untouched so simulation shows floating inputs.
module pic_sync_chain #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/pic_io_port.sv
// PIC16C55 bidirectional port: TRIS and output latches, tri-state pin drive,
// synchronised read-back. Define PIC_IO_CHANGE_IRQ_EN for the change-on-input flag.
module pic_io_port
  import pic_io_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TRIS_RST    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             tris_en,
  input  logic [WIDTH-1:0] din,
  input  logic             bit_en,
  input  logic [2:0]       bit_sel,
  input  logic             bit_val,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] tris_q,
  inout  wire  [WIDTH-1:0] pin_io
`ifdef PIC_IO_CHANGE_IRQ_EN
  ,
  input  logic             chg_clr,
  output logic             chg_irq
`endif
);

  logic [WIDTH-1:0] out_latch_q, out_latch_d;
  logic [WIDTH-1:0] tris_d;

  // Pins follow registered state only, so they move on the edge that captures a write.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign pin_io[i] = tris_q[i] ? 1'bz : out_latch_q[i];
  end

  pic_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pin_io),
    .q   (rd_data)
  );

  // Bit ops start from the pin view (rd_data), so input bits leak into the latch.
  always_comb begin
    out_latch_d = out_latch_q;
    tris_d      = tris_q;
    if (tris_en) begin
      tris_d = din;
    end
    if (wr_en) begin
      out_latch_d = din;
    end else if (bit_en) begin
      out_latch_d = rd_data;
      for (int i = 0; i < WIDTH; i++) begin
        if (bit_sel == 3'(i)) begin
          out_latch_d[i] = (bit_val == BIT_SET);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tris_q      <= TRIS_RST;
      out_latch_q <= '0;
    end else begin
      tris_q      <= tris_d;
      out_latch_q <= out_latch_d;
    end
  end

`ifdef PIC_IO_CHANGE_IRQ_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             chg_irq_d;

  // Shadow holds the pin view at the last core access; only input bits can flag.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en || tris_en || bit_en) begin
      shadow_d = rd_data;
    end
    chg_irq_d = chg_irq | (|((rd_data ^ shadow_q) & tris_q));
    if (chg_clr) begin
      chg_irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      chg_irq  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      chg_irq  <= chg_irq_d;
    end
  end
`endif

endmodule

// File: tb/tb_pic_io_port.sv
// Bench for pic_io_port: an 8-bit and a 4-bit instance share stimulus; a
// spec-level port model feeds a scoreboard queue checked by a monitor.
module tb_pic_io_port;

  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en = 1'b0, tris_en = 1'b0, bit_en = 1'b0, bit_val = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] bit_sel = '0;
  logic [7:0] ext_en = '0, ext_val = '0;

  wire  [7:0] pin8;
  wire  [3:0] pin4;
  logic [7:0] rd8, tris8;
  logic [3:0] rd4, tris4;

  for (genvar i = 0; i < 8; i++) begin : g_ext8
    assign pin8[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end
  for (genvar i = 0; i < 4; i++) begin : g_ext4
    assign pin4[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

`ifdef PIC_IO_CHANGE_IRQ_EN
  logic chg_clr = 1'b0;
  logic chg_irq8, chg_irq4;
`endif

  pic_io_port #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .tris_en(tris_en), .din(din),
    .bit_en(bit_en), .bit_sel(bit_sel), .bit_val(bit_val),
    .rd_data(rd8), .tris_q(tris8), .pin_io(pin8)
`ifdef PIC_IO_CHANGE_IRQ_EN
    , .chg_clr(chg_clr), .chg_irq(chg_irq8)
`endif
  );

  pic_io_port #(.WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .tris_en(tris_en), .din(din[3:0]),
    .bit_en(bit_en), .bit_sel(bit_sel), .bit_val(bit_val),
    .rd_data(rd4), .tris_q(tris4), .pin_io(pin4)
`ifdef PIC_IO_CHANGE_IRQ_EN
    , .chg_clr(chg_clr), .chg_irq(chg_irq4)
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0]  tris_m, latch_m;
  logic [7:0]  pin_hist[$];   // pin samples still in flight to rd_data
  logic [35:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic model_reset();
    tris_m  = 8'hFF;
    latch_m = 8'h00;
    pin_hist.delete();
    for (int i = 0; i < SYNC; i++) pin_hist.push_back(8'h00);
  endtask

  // Called at a falling edge: applies one cycle of stimulus, predicts the
  // state after the next rising edge, then waits for the next falling edge.
  task automatic drive_cycle(input logic w, input logic t, input logic b,
                             input logic [7:0] d, input logic [2:0] sel,
                             input logic v, input logic [7:0] ext_pref);
    logic [7:0] rd_now, latch_new, tris_new, to_out, ext_v, sample;
    rd_now    = pin_hist[0];
    tris_new  = t ? d : tris_m;
    latch_new = latch_m;
    if (w) begin
      latch_new = d;
    end else if (b) begin
      latch_new      = rd_now;
      latch_new[sel] = v;
    end
    // Bits turning into outputs: bench keeps driving them with the value the
    // port is about to drive, so the hand-over never conflicts.
    to_out = tris_m & ~tris_new;
    ext_v  = (ext_pref & ~to_out) | (latch_new & to_out);
    wr_en = w; tris_en = t; bit_en = b; din = d; bit_sel = sel; bit_val = v;
    ext_en  = tris_m;
    ext_val = ext_v;
    sample  = (tris_m & ext_v) | (~tris_m & latch_m);
    pin_hist.push_back(sample);
    void'(pin_hist.pop_front());
    tris_m  = tris_new;
    latch_m = latch_new;
    exp_q.push_back({tris_m, pin_hist[0], latch_m & ~tris_m,
                     tris_m[3:0], pin_hist[0][3:0], latch_m[3:0] & ~tris_m[3:0]});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] ext_pref);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, ext_pref);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [35:0] exp, act;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {tris8, rd8, pin8 & ~tris8, tris4, rd4, pin4 & ~tris4};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL sb_port @%0t: got tris8=%h rd8=%h pins8=%h tris4=%h rd4=%h pins4=%h expected tris8=%h rd8=%h pins8=%h tris4=%h rd4=%h pins4=%h",
                 $time, act[35:28], act[27:20], act[19:12], act[11:8], act[7:4], act[3:0],
                 exp[35:28], exp[27:20], exp[19:12], exp[11:8], exp[7:4], exp[3:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_tris8", tris8, 8'hFF);
    check("rst_tris4", {4'h0, tris4}, 8'h0F);
    check("rst_rd8", rd8, 8'h00);
    check("rst_rd4", {4'h0, rd4}, 8'h00);
    rst = 1'b0;

    // All outputs, write A5: pins next edge, rd_data two edges later.
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 8'h00);
    idle(3, 8'h00);

    // Async reset in the middle of a write, observed with no clock edge.
    wr_en = 1'b1; din = 8'h5A;
    #2 rst = 1'b1;
    #1;
    check("async_tris8", tris8, 8'hFF);
    check("async_rd8", rd8, 8'h00);
    check("async_tris4", {4'h0, tris4}, 8'h0F);
    check("async_rd4", {4'h0, rd4}, 8'h00);
    @(negedge clk);
    wr_en = 1'b0;
    model_reset();
    rst = 1'b0;
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);  // latch shows 00

    // High nibble input carrying C, then BSF bit 0 copies pin bits into latch.
    drive_cycle(1'b0, 1'b1, 1'b0, 8'hF0, 3'd0, 1'b0, 8'hC0);
    drive_cycle(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'hC0);
    idle(2, 8'hC0);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 8'hC0);
    idle(1, 8'hC0);

    // wr_en beats bit_en; wr_en with tris_en lands together.
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b1, 8'h3C, 3'd7, 1'b1, 8'h00);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'h0F, 3'd0, 1'b0, 8'h90);
    idle(2, 8'h90);

    // Out-of-range bit index (5 on the 4-bit port) and a BCF.
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h5A, 3'd0, 1'b0, 8'h6B);
    idle(2, 8'hE7);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00, 3'd5, 1'b1, 8'hE7);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00, 3'd6, 1'b0, 8'h18);
    idle(2, 8'h18);

    // Randomised traffic, strobes may stay high over several cycles.
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 2) == 0, 8'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom), 8'($urandom));
    end
    idle(2, 8'h00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
